// File: rtl/eif_mon_pkg.sv
// Shared widths, rate FSM states and helpers for the EIF spike monitor.
package eif_mon_pkg;

    localparam int ISI_W      = 16;
    localparam int RATE_W     = 8;
    localparam int WIN_W      = 16;
    localparam int FIFO_DEPTH = 4;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_COUNT
    } rate_st_e;

    function automatic logic [31:0] sat_inc(
        input logic [31:0] v,
        input logic [31:0] maxv
    );
        return (v >= maxv) ? maxv : v + 32'd1;
    endfunction

endpackage

// File: rtl/eif_isi_if.sv
// ISI stream handshake: head value, non-empty flag and consumer accept.
interface eif_isi_if
    import eif_mon_pkg::*;
#(
    parameter int W = ISI_W
);

    logic [W-1:0] isi_data;
    logic         isi_valid;
    logic         isi_ready;

    modport master (
        output isi_data,
        output isi_valid,
        input  isi_ready
    );

    modport slave (
        input  isi_data,
        input  isi_valid,
        output isi_ready
    );

endinterface

// File: rtl/eif_isi_fifo.sv
// First-word-fall-through FIFO for ISI values; reports pushes lost to a full queue.
module eif_isi_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         empty_o,
    output logic         drop_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wptr_q;
    logic [AW:0]  rptr_q;
    logic         full;
    logic         empty;
    logic         pop_ok;
    logic         push_ok;

    // Extra pointer bit separates full from empty when the indices match.
    assign full    = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty   = (wptr_q == rptr_q);
    assign pop_ok  = pop_i & ~empty;
    assign push_ok = push_i & (~full | pop_ok);

    assign data_o  = mem_q[rptr_q[AW-1:0]];
    assign empty_o = empty;
    assign drop_o  = push_i & full & ~pop_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem_q[wptr_q[AW-1:0]] <= data_i;
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop_ok) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/eif_spike_monitor.sv
// Spike edge detector, inter-spike-interval queue and windowed firing-rate counter.
module eif_spike_monitor
    import eif_mon_pkg::*;
#(
    parameter int ISI_W      = eif_mon_pkg::ISI_W,
    parameter int RATE_W     = eif_mon_pkg::RATE_W,
    parameter int WIN_W      = eif_mon_pkg::WIN_W,
    parameter int FIFO_DEPTH = eif_mon_pkg::FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spike_in,
    input  logic [WIN_W-1:0]  win_len,
    input  logic              clear_ovf,
    eif_isi_if.master         isi,
    output logic [RATE_W-1:0] rate,
    output logic              rate_valid,
    output logic              overflow
);

    localparam logic [ISI_W-1:0]  ISI_MAX  = '1;
    localparam logic [RATE_W-1:0] RATE_MAX = '1;

    logic              spike_d_q;
    logic              primed_q;
    logic [ISI_W-1:0]  isi_cnt_q;
    logic [ISI_W-1:0]  isi_cnt_d;
    logic              overflow_q;
    logic              overflow_d;
    rate_st_e          st_q;
    rate_st_e          st_d;
    logic [WIN_W-1:0]  win_lat_q;
    logic [WIN_W-1:0]  win_lat_d;
    logic [WIN_W-1:0]  win_cnt_q;
    logic [WIN_W-1:0]  win_cnt_d;
    logic [RATE_W-1:0] spk_cnt_q;
    logic [RATE_W-1:0] spk_cnt_d;
    logic [RATE_W-1:0] spk_inc;
    logic [RATE_W-1:0] rate_q;
    logic [RATE_W-1:0] rate_d;
    logic              rate_valid_q;
    logic              rate_valid_d;
    logic              spk_edge;
    logic              isi_push;
    logic              isi_pop;
    logic              fifo_empty;
    logic              fifo_drop;
    logic [ISI_W-1:0]  fifo_data;

    assign spk_edge  = spike_in & ~spike_d_q;
    assign isi_push  = spk_edge & primed_q;
    assign isi_pop   = isi.isi_ready & ~fifo_empty;
    assign isi_cnt_d = spk_edge ? ISI_W'(1) :
                       ISI_W'(sat_inc(32'(isi_cnt_q), 32'(ISI_MAX)));

    // A drop in the same cycle as a clear leaves the flag set.
    assign overflow_d = fifo_drop ? 1'b1 :
                        (clear_ovf ? 1'b0 : overflow_q);

    eif_isi_fifo #(
        .W     (ISI_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (isi_push),
        .data_i  (isi_cnt_q),
        .pop_i   (isi_pop),
        .data_o  (fifo_data),
        .empty_o (fifo_empty),
        .drop_o  (fifo_drop)
    );

    assign isi.isi_data  = fifo_data;
    assign isi.isi_valid = ~fifo_empty;

    assign spk_inc = spk_edge ?
                     RATE_W'(sat_inc(32'(spk_cnt_q), 32'(RATE_MAX))) :
                     spk_cnt_q;

    always_comb begin
        st_d         = st_q;
        win_lat_d    = win_lat_q;
        win_cnt_d    = win_cnt_q;
        spk_cnt_d    = spk_cnt_q;
        rate_d       = rate_q;
        rate_valid_d = 1'b0;
        unique case (st_q)
            ST_IDLE: begin
                win_cnt_d = '0;
                spk_cnt_d = '0;
                if (win_len != '0) begin
                    st_d      = ST_COUNT;
                    win_lat_d = win_len;
                end
            end
            ST_COUNT: begin
                // New window length is only sampled at a window boundary.
                if (win_cnt_q == win_lat_q - WIN_W'(1)) begin
                    rate_d       = spk_inc;
                    rate_valid_d = 1'b1;
                    win_cnt_d    = '0;
                    spk_cnt_d    = '0;
                    win_lat_d    = win_len;
                    if (win_len == '0) begin
                        st_d = ST_IDLE;
                    end
                end else begin
                    win_cnt_d = win_cnt_q + WIN_W'(1);
                    spk_cnt_d = spk_inc;
                end
            end
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            spike_d_q    <= 1'b0;
            primed_q     <= 1'b0;
            isi_cnt_q    <= '0;
            overflow_q   <= 1'b0;
            st_q         <= ST_IDLE;
            win_lat_q    <= '0;
            win_cnt_q    <= '0;
            spk_cnt_q    <= '0;
            rate_q       <= '0;
            rate_valid_q <= 1'b0;
        end else begin
            spike_d_q    <= spike_in;
            primed_q     <= primed_q | spk_edge;
            isi_cnt_q    <= isi_cnt_d;
            overflow_q   <= overflow_d;
            st_q         <= st_d;
            win_lat_q    <= win_lat_d;
            win_cnt_q    <= win_cnt_d;
            spk_cnt_q    <= spk_cnt_d;
            rate_q       <= rate_d;
            rate_valid_q <= rate_valid_d;
        end
    end

    assign rate       = rate_q;
    assign rate_valid = rate_valid_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_eif_spike_monitor.sv
// Scoreboard bench for eif_spike_monitor: directed scenarios plus random traffic.
module tb_eif_spike_monitor;
    import eif_mon_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              spike_in;
    logic [WIN_W-1:0]  win_len;
    logic              clear_ovf;
    logic              isi_ready;
    logic [RATE_W-1:0] rate;
    logic              rate_valid;
    logic              overflow;

    eif_isi_if #(.W(ISI_W)) isi ();
    assign isi.isi_ready = isi_ready;

    eif_spike_monitor #(
        .ISI_W      (ISI_W),
        .RATE_W     (RATE_W),
        .WIN_W      (WIN_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .spike_in   (spike_in),
        .win_len    (win_len),
        .clear_ovf  (clear_ovf),
        .isi        (isi),
        .rate       (rate),
        .rate_valid (rate_valid),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    // Reference state: absolute cycle times of edges and windows.
    int     q_isi[$];
    int     rq[$];
    bit     m_prev;
    bit     m_primed;
    bit     m_ovf;
    int     m_rate;
    longint m_last;
    longint cyc = 0;
    bit     win_on;
    longint win_start;
    longint win_l;
    int     win_edges;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("isi_valid", 64'(isi.isi_valid), 64'(q_isi.size() != 0));
            if (q_isi.size() != 0 && isi_ready) begin
                chk("isi_data", 64'(isi.isi_data), 64'(q_isi.pop_front()));
            end
            chk("rate_valid", 64'(rate_valid), 64'(rq.size() != 0));
            if (rq.size() != 0) begin
                chk("rate_pulse", 64'(rate), 64'(rq.pop_front()));
            end
            chk("rate_hold", 64'(rate), 64'(m_rate));
            chk("overflow", 64'(overflow), 64'(m_ovf));
        end
    end

    task automatic model_step();
        bit     e;
        bit     drop;
        longint d;
        cyc++;
        if (rst) begin
            q_isi.delete();
            rq.delete();
            m_prev    = 1'b0;
            m_primed  = 1'b0;
            m_ovf     = 1'b0;
            m_rate    = 0;
            win_on    = 1'b0;
            win_edges = 0;
        end else begin
            e      = spike_in && !m_prev;
            m_prev = spike_in;
            drop   = 1'b0;
            if (e) begin
                if (m_primed) begin
                    d = cyc - m_last;
                    if (d > 65535) d = 65535;
                    if (q_isi.size() >= FIFO_DEPTH) drop = 1'b1;
                    else q_isi.push_back(int'(d));
                end
                m_primed = 1'b1;
                m_last   = cyc;
            end
            if (drop) m_ovf = 1'b1;
            else if (clear_ovf) m_ovf = 1'b0;
            if (!win_on) begin
                if (win_len != 0) begin
                    win_on    = 1'b1;
                    win_start = cyc + 1;
                    win_l     = longint'(win_len);
                    win_edges = 0;
                end
            end else begin
                if (e) win_edges++;
                if (cyc == win_start + win_l - 1) begin
                    m_rate = (win_edges > 255) ? 255 : win_edges;
                    rq.push_back(m_rate);
                    win_edges = 0;
                    if (win_len == 0) begin
                        win_on = 1'b0;
                    end else begin
                        win_start = cyc + 1;
                        win_l     = longint'(win_len);
                    end
                end
            end
        end
    endtask

    always @(negedge clk) begin
        #2;
        model_step();
    end

    task automatic cyc1();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit s, input int n);
        spike_in = s;
        repeat (n) cyc1();
    endtask

    task automatic do_reset(input int n);
        spike_in  = 1'b0;
        clear_ovf = 1'b0;
        rst       = 1'b1;
        repeat (n) cyc1();
        rst = 1'b0;
        chk("isi_data_rst", 64'(isi.isi_data), 64'd0);
    endtask

    int wl[5] = '{0, 1, 3, 17, 64};

    initial begin
        rst       = 1'b1;
        spike_in  = 1'b0;
        win_len   = '0;
        clear_ovf = 1'b0;
        isi_ready = 1'b1;
        do_reset(2);
        mon_en = 1'b1;

        // Edges at 10, 25, 27: first only primes.
        for (int i = 0; i < 40; i++) begin
            spike_in = (i == 10 || i == 25 || i == 27);
            cyc1();
        end

        // Held level counts once.
        do_reset(1);
        drive(1, 5);
        drive(0, 3);
        drive(1, 1);
        drive(0, 10);

        // Fill, overflow, clear, push+pop on full, drop beats clear.
        do_reset(1);
        isi_ready = 1'b0;
        repeat (6) begin
            drive(1, 1);
            drive(0, 3);
        end
        drive(0, 2);
        clear_ovf = 1'b1;
        cyc1();
        clear_ovf = 1'b0;
        drive(0, 2);
        isi_ready = 1'b1;
        drive(1, 1);
        isi_ready = 1'b0;
        drive(0, 3);
        clear_ovf = 1'b1;
        drive(1, 1);
        clear_ovf = 1'b0;
        drive(0, 2);
        clear_ovf = 1'b1;
        cyc1();
        clear_ovf = 1'b0;
        isi_ready = 1'b1;
        drive(0, 8);

        // ISI counter saturation.
        drive(1, 1);
        drive(0, 70000);
        drive(1, 1);
        drive(0, 4);

        // Rate windows with mid-window length change, then disable.
        do_reset(1);
        win_len = 16'd100;
        for (int i = 0; i < 400; i++) begin
            if (i == 150) win_len = 16'd50;
            spike_in = (i % 10 == 0);
            cyc1();
        end
        win_len = '0;
        for (int i = 0; i < 150; i++) begin
            spike_in = (i % 10 == 0);
            cyc1();
        end

        // Rate count saturation.
        win_len = 16'd600;
        for (int i = 0; i < 1300; i++) begin
            spike_in = i[0];
            cyc1();
        end
        win_len = '0;
        drive(0, 700);

        // Reset mid-window with queued ISIs, then re-prime only.
        isi_ready = 1'b0;
        win_len   = 16'd20;
        repeat (3) begin
            drive(1, 1);
            drive(0, 2);
        end
        win_len = '0;
        do_reset(1);
        isi_ready = 1'b1;
        drive(0, 2);
        drive(1, 1);
        drive(0, 5);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                win_len = WIN_W'(wl[$urandom_range(0, 4)]);
            end
            spike_in  = ($urandom_range(0, 2) == 0);
            isi_ready = 1'($urandom_range(0, 1));
            clear_ovf = ($urandom_range(0, 15) == 0);
            rst       = ($urandom_range(0, 499) == 0);
            cyc1();
        end
        rst       = 1'b0;
        clear_ovf = 1'b0;
        win_len   = '0;
        isi_ready = 1'b1;
        drive(0, 80);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
